// File: rtl/gray_ptr_rx_32.sv
// Read-side endpoint for a Gray-coded 5-bit write pointer from another clock domain.
// Synchronizes and decodes the remote pointer, tracks the local read pointer,
// and traps illegal multi-step jumps until an explicit clear resynchronizes.
module gray_ptr_rx_32 #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] gray_in,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [4:0] wr_bin,
  output logic [4:0] rd_bin,
  output logic [4:0] rd_gray,
  output logic [4:0] level,
  output logic       empty,
  output logic       rd_ok,
  output logic       ptr_err
);

  localparam int unsigned PTR_W = 5;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_ERR    = 2'd1,
    ST_RESYNC = 2'd2
  } state_t;

  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = int'(PTR_W) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [PTR_W-1:0] sync_q [SYNC_STAGES];
  state_t           state_q, state_d;
  logic [PTR_W-1:0] wr_bin_q, wr_bin_d;
  logic [PTR_W-1:0] rd_bin_q, rd_bin_d;
  logic [PTR_W-1:0] rd_gray_q, rd_gray_d;
  logic             ptr_err_q, ptr_err_d;
  logic [PTR_W-1:0] dec;
  logic [PTR_W-1:0] delta;
  logic [PTR_W-1:0] rd_bin_inc;

  // Plain flop chain bringing gray_in into the clk domain
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Decoded remote pointer, its step against the accepted value, and queue status
  always_comb begin
    dec        = gray2bin(sync_q[SYNC_STAGES-1]);
    delta      = dec - wr_bin_q;
    rd_bin_inc = rd_bin_q + PTR_W'(1);
    level      = wr_bin_q - rd_bin_q;
    empty      = (level == '0) || (state_q != ST_RUN);
    rd_ok      = rd_en && !empty;
  end

  // Next-state and pointer updates
  always_comb begin
    state_d   = state_q;
    wr_bin_d  = wr_bin_q;
    rd_bin_d  = rd_bin_q;
    rd_gray_d = rd_gray_q;
    ptr_err_d = ptr_err_q;

    // A pop is judged on this cycle's status, even if a jump is detected now
    if (rd_ok) begin
      rd_bin_d  = rd_bin_inc;
      rd_gray_d = bin2gray(rd_bin_inc);
    end

    case (state_q)
      ST_RUN: begin
        if (delta <= PTR_W'(1)) begin
          wr_bin_d = dec;
        end else begin
          ptr_err_d = 1'b1;
          state_d   = ST_ERR;
        end
      end
      ST_ERR: begin
        if (clr_err) state_d = ST_RESYNC;
      end
      ST_RESYNC: begin
        // Adopt the remote pointer and flush everything outstanding
        wr_bin_d  = dec;
        rd_bin_d  = dec;
        rd_gray_d = bin2gray(dec);
        ptr_err_d = 1'b0;
        state_d   = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State and pointer registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_RUN;
      wr_bin_q  <= '0;
      rd_bin_q  <= '0;
      rd_gray_q <= '0;
      ptr_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_bin_q  <= wr_bin_d;
      rd_bin_q  <= rd_bin_d;
      rd_gray_q <= rd_gray_d;
      ptr_err_q <= ptr_err_d;
    end
  end

  assign wr_bin  = wr_bin_q;
  assign rd_bin  = rd_bin_q;
  assign rd_gray = rd_gray_q;
  assign ptr_err = ptr_err_q;

endmodule

// File: tb/tb_gray_ptr_rx_32.sv
// Directed bench for gray_ptr_rx_32 with hand-computed expectations.
module tb_gray_ptr_rx_32;

  logic       clk;
  logic       reset_n;
  logic [4:0] gray_in;
  logic       rd_en;
  logic       clr_err;
  logic [4:0] wr_bin;
  logic [4:0] rd_bin;
  logic [4:0] rd_gray;
  logic [4:0] level;
  logic       empty;
  logic       rd_ok;
  logic       ptr_err;

  int n_checks;
  int n_errors;

  gray_ptr_rx_32 #(.SYNC_STAGES(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .gray_in (gray_in),
    .rd_en   (rd_en),
    .clr_err (clr_err),
    .wr_bin  (wr_bin),
    .rd_bin  (rd_bin),
    .rd_gray (rd_gray),
    .level   (level),
    .empty   (empty),
    .rd_ok   (rd_ok),
    .ptr_err (ptr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] to_gray(input int v);
    logic [4:0] b;
    b = 5'(v);
    return b ^ {1'b0, b[4:1]};
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    gray_in  = 5'b10110;
    rd_en    = 1'b0;
    clr_err  = 1'b0;

    // Reset hold with a nonzero remote pointer
    repeat (3) step();
    check("rst_wr_bin",  32'(wr_bin),  0);
    check("rst_rd_bin",  32'(rd_bin),  0);
    check("rst_rd_gray", 32'(rd_gray), 0);
    check("rst_level",   32'(level),   0);
    check("rst_empty",   32'(empty),   1);
    check("rst_rd_ok",   32'(rd_ok),   0);
    check("rst_ptr_err", 32'(ptr_err), 0);

    // Released with 10110 (binary 27) held: delta 27 is a jump
    reset_n = 1'b1;
    step();
    step();
    check("rel_no_err_yet", 32'(ptr_err), 0);
    step();
    check("rel_jump_err",   32'(ptr_err), 1);
    check("rel_wr_hold",    32'(wr_bin),  0);
    check("rel_empty",      32'(empty),   1);

    // Clean restart
    reset_n = 1'b0;
    gray_in = 5'b00000;
    repeat (2) step();
    reset_n = 1'b1;
    repeat (3) step();
    check("restart_ptr_err", 32'(ptr_err), 0);

    // Latency: wr_bin follows on the third edge after gray_in changes
    gray_in = 5'b00001;
    step();
    step();
    check("lat_edge2_wr", 32'(wr_bin), 0);
    step();
    check("lat_edge3_wr", 32'(wr_bin), 1);
    check("lat_level",    32'(level),  1);
    check("lat_empty",    32'(empty),  0);
    rd_en = 1'b1;
    #1;
    check("lat_rd_ok", 32'(rd_ok), 1);
    step();
    rd_en = 1'b0;
    check("pop_rd_bin",  32'(rd_bin),  1);
    check("pop_rd_gray", 32'(rd_gray), 1);
    check("pop_empty",   32'(empty),   1);

    // Walk through every code including the 31->0 wrap, popping each entry
    for (int v = 2; v <= 32; v++) begin
      gray_in = to_gray(v);
      repeat (3) step();
      check("wrap_wr_bin", 32'(wr_bin), 32'(v % 32));
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      check("wrap_rd_bin",  32'(rd_bin),  32'(v % 32));
      check("wrap_rd_gray", 32'(rd_gray), 32'(to_gray(v)));
      check("wrap_ptr_err", 32'(ptr_err), 0);
    end
    check("wrap_end_rd_gray", 32'(rd_gray), 0);

    // Advance to wr_bin=3 without popping
    for (int v = 1; v <= 3; v++) begin
      gray_in = to_gray(v);
      repeat (3) step();
    end
    check("pre_jump_wr", 32'(wr_bin), 3);
    check("pre_jump_level", 32'(level), 3);

    // Jump 3 -> 5 (gray 00111)
    gray_in = 5'b00111;
    repeat (3) step();
    check("jump_ptr_err", 32'(ptr_err), 1);
    check("jump_empty",   32'(empty),   1);
    check("jump_wr_hold", 32'(wr_bin),  3);
    check("jump_level",   32'(level),   3);
    rd_en = 1'b1;
    #1;
    check("jump_rd_ok", 32'(rd_ok), 0);
    step();
    rd_en = 1'b0;
    check("jump_rd_hold", 32'(rd_bin), 0);

    // Clear: one cycle in RESYNC, then pointers adopt the remote value
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("resync_err_held", 32'(ptr_err), 1);
    check("resync_empty",    32'(empty),   1);
    step();
    check("clr_wr_bin",  32'(wr_bin),  5);
    check("clr_rd_bin",  32'(rd_bin),  5);
    check("clr_rd_gray", 32'(rd_gray), 7);
    check("clr_level",   32'(level),   0);
    check("clr_ptr_err", 32'(ptr_err), 0);

    // Pops against an empty queue are ignored
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("empty_pop_rd_ok", 32'(rd_ok), 0);
      step();
    end
    rd_en = 1'b0;
    check("empty_pop_rd_bin",  32'(rd_bin),  5);
    check("empty_pop_ptr_err", 32'(ptr_err), 0);

    // Reach wr_bin=12, then force ERR
    for (int v = 6; v <= 12; v++) begin
      gray_in = to_gray(v);
      repeat (3) step();
    end
    check("mid_wr_bin", 32'(wr_bin), 12);
    check("mid_level",  32'(level),  7);
    gray_in = to_gray(20);
    repeat (3) step();
    check("mid_err",     32'(ptr_err), 1);
    check("mid_wr_hold", 32'(wr_bin),  12);

    // One-cycle reset from ERR
    reset_n = 1'b0;
    gray_in = 5'b00000;
    step();
    reset_n = 1'b1;
    check("mrst_wr_bin",  32'(wr_bin),  0);
    check("mrst_rd_bin",  32'(rd_bin),  0);
    check("mrst_rd_gray", 32'(rd_gray), 0);
    check("mrst_level",   32'(level),   0);
    check("mrst_empty",   32'(empty),   1);
    check("mrst_ptr_err", 32'(ptr_err), 0);

    // Back in RUN: a legal step is accepted
    gray_in = to_gray(1);
    repeat (3) step();
    check("mrst_run_wr",  32'(wr_bin),  1);
    check("mrst_run_err", 32'(ptr_err), 0);
    check("mrst_run_empty", 32'(empty), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gray_ptr_rx_32.md
Name: gray_ptr_rx_32

Overview:
Read-side endpoint for a 5-bit Gray-coded write pointer arriving from another clock domain. It synchronizes the pointer and decodes it to binary. It maintains the local 32-entry read pointer in both binary and Gray form and produces occupancy, empty and read-accept signals. It also detects illegal multi-step pointer jumps and requires an explicit clear to recover.

Parameters:
SYNC_STAGES, 2, number of flops in the gray_in synchronizer chain; legal values are 2 and 3.

Ports:
clk  input  1  read-domain clock
reset_n  input  1  synchronous, active-low reset, sampled on rising edge of clk
gray_in  input  5  remote write pointer, standard reflected Gray code, asynchronous to clk
rd_en  input  1  consumer requests one pop this cycle
clr_err  input  1  acknowledge pointer error and resynchronize
wr_bin  output  5  accepted remote pointer, binary
rd_bin  output  5  local read pointer, binary
rd_gray  output  5  local read pointer, Gray; registered and suitable for return to the write domain
level  output  5  (wr_bin - rd_bin) mod 32
empty  output  1  no entry can be popped
rd_ok  output  1  pop accepted this cycle, combinational
ptr_err  output  1  sticky pointer-jump error flag

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - All synchronizer stages, wr_bin, rd_bin, rd_gray and ptr_err go to 0.
  - State goes to RUN.
  - Therefore level=0, empty=1, rd_ok=0.
  - Reset overrides every other input, in any state.
- Synchronizer: gray_in passes through SYNC_STAGES flops with no logic between stages.
- Decode: dec = gray2bin(last stage), where bit4 = g4 and bit i = bit(i+1) XOR g(i).
- Step check: delta = (dec - wr_bin) mod 32. Only delta 0 or 1 is legal. The wrap 31->0 (Gray 10000->00000) is delta 1 and is legal.
- State machine: RUN, ERR, RESYNC.
  - RUN, legal delta: wr_bin <= dec. Latency from a gray_in change to wr_bin is SYNC_STAGES+1 clk edges.
  - RUN, delta not in {0,1}: wr_bin holds, ptr_err <= 1, next state ERR.
  - ERR: step check is suspended, wr_bin and rd pointers hold, empty forced to 1. On clr_err=1, next state RESYNC; otherwise stay in ERR.
  - RESYNC (exactly one cycle): wr_bin <= dec, rd_bin <= dec, rd_gray <= bin2gray(dec), ptr_err <= 0, next state RUN. This flushes all entries.
  - clr_err in RUN or RESYNC has no effect.
- level is combinational: (wr_bin - rd_bin) mod 32, 5-bit wrap. A full 32-entry queue is indistinguishable from empty; the writer must keep at most 31 entries outstanding.
- empty = (level==0) OR (state != RUN).
- rd_ok = rd_en AND NOT empty. rd_en while empty is ignored silently and is not an error.
- On rd_ok: rd_bin <= rd_bin+1 (mod 32) and rd_gray <= bin2gray(rd_bin+1) on the same edge, so rd_gray always equals bin2gray(rd_bin).
- Simultaneous wr_bin advance and rd_ok: both apply; level reflects both on the next cycle. A pop is judged only against the current-cycle level.
- An illegal jump and rd_en in the same cycle: the pop is still accepted if empty=0 that cycle. The error takes effect from the next cycle.

Test Plan:
- Reset hold: reset_n=0 for 3 cycles with gray_in=10110 -> all outputs 0, empty=1, ptr_err=0. After release with gray_in held, the step check flags delta 27 -> ptr_err=1.
- Latency, SYNC_STAGES=2: gray_in 00000->00001 at edge 0 -> wr_bin=1 after edge 3, level=1, empty=0. Then rd_en=1 for one cycle -> rd_ok=1, rd_bin=1, rd_gray=00001, empty=1.
- Wrap: step gray_in through all 32 codes to 10000 then 00000 while popping as entries become available -> no ptr_err. rd_bin goes 31->0 and rd_gray goes 10000->00000.
- Jump error: with wr_bin=3 (gray 00010), drive gray_in=00111 (binary 5) -> ptr_err=1, empty=1, wr_bin stays 3. rd_en is ignored. Pulse clr_err -> one cycle later wr_bin=5, rd_bin=5, rd_gray=00111, level=0, ptr_err=0.
- Empty pop: level=0, rd_en=1 for 4 cycles -> rd_ok=0, rd_bin unchanged, ptr_err=0.
- Mid-operation reset: in ERR with wr_bin=12, assert reset_n=0 for one cycle -> next cycle all outputs 0, state RUN, ptr_err=0.
